uart_rx_multi: RTL and testbench

// - Next-generation UART receiver with configurable frame format, 16x oversampling, 3-sample

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the multi-format UART receiver.
// Holds the parity mode codes, the receive and read state encodings, the RX FIFO
// entry layout, the o_rdata bit-field offsets and the tick divisor helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned ENTRY_W     = 10;
    localparam int unsigned RDATA_W     = 32;

    localparam int unsigned RD_DATA_LSB = 0;
    localparam int unsigned RD_PERR_BIT = 8;
    localparam int unsigned RD_FERR_BIT = 9;
    localparam int unsigned RD_OVR_BIT  = 10;
    localparam int unsigned RD_FILL_LSB = 16;
    localparam int unsigned RD_FILL_W   = 16;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_HOLD
    } rd_state_t;

    // One received byte plus its error status, as stored in the FIFO.
    typedef struct packed {
        logic       err_f;
        logic       err_p;
        logic [7:0] data;
    } rx_entry_t;

    // Clocks per 1/16 bit, truncated, never below one.
    function automatic int unsigned calc_div(input int unsigned clock_rate,
                                             input int unsigned baud_rate);
        int unsigned d;
        d = clock_rate / (baud_rate * 16);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock RX FIFO with registered read data.
// Ports: i_clock, i_reset (sync, active high), i_push/i_wdata write side,
// i_pop read side (o_rdata valid the cycle after a pop), o_empty, o_full, o_count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        count_nxt = o_count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = o_count + CW'(1);
            2'b01:   count_nxt = o_count - CW'(1);
            default: count_nxt = o_count;
        endcase
    end

    // Storage array, no reset needed.
    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // Pointers, fill level and flags; flags are registered from the next count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_rdata <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                o_rdata <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            o_count <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_rx_multi.sv
// Memory-mapped UART receiver: 16x oversampling, 3-sample majority vote,
// configurable data/parity/stop format, per-byte error status, RX FIFO.
// Ports: i_clock, i_reset (sync, active high), i_enable (bus read request),
// o_rdata {fill[31:16], 0, overrun[10], err_f[9], err_p[8], data[7:0]},
// o_ready (read data valid), o_waiting (read pending on empty FIFO), UART_RX (async line).
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_waiting,
    input  logic        UART_RX
);

    localparam int unsigned DIV = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW  = 3;

    logic                  rx_meta;
    logic                  rx_s;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;

    rx_state_t             state;
    logic [3:0]            s;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  smp7;
    logic                  smp8;
    logic                  maj;
    logic                  err_p;
    logic                  err_f;
    logic                  f_last;
    logic                  par_bad;
    logic                  push_req;
    rx_entry_t             push_entry;

    rd_state_t             rd_state;
    logic                  rd_pop;
    logic                  overrun;
    logic                  overrun_set;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [RDATA_W-1:0]    rdata_nxt;

    // Two-flop synchroniser. Resetting to 0 forces ARM to see a genuinely
    // idle line before the first start bit can be accepted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // 16x oversampling tick enable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TW'(DIV - 1));

    // Majority of samples 7, 8 and the live sample 9.
    assign maj     = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
    assign f_last  = err_f | ~maj;
    assign par_bad = (^{shreg, maj}) != (PARITY == PARITY_ODD);

    // Receive state machine; all actions happen on ticks.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_ARM;
            s          <= 4'd0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            smp7       <= 1'b0;
            smp8       <= 1'b0;
            err_p      <= 1'b0;
            err_f      <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= 1'b0;
            if (tick) begin
                if (s == 4'd7) begin
                    smp7 <= rx_s;
                end
                if (s == 4'd8) begin
                    smp8 <= rx_s;
                end
                s <= s + 4'd1;
                case (state)
                    ST_ARM: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        // The detecting tick counts as sample 0 of the start bit.
                        s <= 4'd1;
                        if (!rx_s) begin
                            state <= ST_START;
                            err_p <= 1'b0;
                            err_f <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (s == 4'd9 && maj) begin
                            state <= ST_IDLE;
                        end else if (s == 4'd15) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        // LSB first: shift new bits in at the top.
                        if (s == 4'd9) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (s == 4'd15) begin
                            if (bit_idx == BW'(DATA_BITS - 1)) begin
                                state    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (s == 4'd9) begin
                            err_p <= par_bad;
                        end
                        if (s == 4'd15) begin
                            state    <= ST_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                    ST_STOP: begin
                        if (s == 4'd9) begin
                            err_f <= f_last;
                            if (stop_idx == 1'(STOP_BITS - 1)) begin
                                push_req         <= 1'b1;
                                push_entry.err_f <= f_last;
                                push_entry.err_p <= err_p;
                                push_entry.data  <= 8'(shreg);
                                // A low line here is a break: wait for idle.
                                state            <= rx_s ? ST_IDLE : ST_ARM;
                            end
                        end else if (s == 4'd15) begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                    default: state <= ST_ARM;
                endcase
            end
        end
    end

    assign rd_pop      = (rd_state == RD_IDLE) && i_enable && !fifo_empty;
    assign overrun_set = push_req && fifo_full && !rd_pop;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push_req),
        .i_wdata (push_entry),
        .i_pop   (rd_pop),
        .o_rdata (fifo_rdata),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_count (fifo_count)
    );

    // Read word assembled from the popped entry and the post-pop fill level.
    always_comb begin
        rdata_nxt                                = '0;
        rdata_nxt[RD_FILL_LSB +: RD_FILL_W]      = RD_FILL_W'(fifo_count);
        rdata_nxt[RD_OVR_BIT]                    = overrun;
        rdata_nxt[RD_FERR_BIT:RD_DATA_LSB]       = fifo_rdata;
    end

    // Bus read handshake: pop, load, then hold until i_enable drops.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd_state  <= RD_IDLE;
            o_rdata   <= '0;
            o_ready   <= 1'b0;
            o_waiting <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            case (rd_state)
                RD_IDLE: begin
                    o_ready <= 1'b0;
                    if (rd_pop) begin
                        rd_state  <= RD_LOAD;
                        o_waiting <= 1'b0;
                    end else begin
                        o_waiting <= i_enable;
                    end
                end
                RD_LOAD: begin
                    o_rdata <= rdata_nxt;
                    // A drop arriving this very cycle must survive the clear.
                    if (!overrun_set) begin
                        overrun <= 1'b0;
                    end
                    o_ready  <= i_enable;
                    rd_state <= i_enable ? RD_HOLD : RD_IDLE;
                end
                RD_HOLD: begin
                    if (!i_enable) begin
                        o_ready   <= 1'b0;
                        o_waiting <= 1'b0;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: three instances (8N1/32, 7O1/32, 8N1/4) at DIV=2,
// 32 clocks per bit. Directed vector table, hand-written corner sequences and
// randomized frames checked against a queue-based reference model.
module tb_uart_rx_multi;

    localparam int unsigned BIT_CLKS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  line;
    logic [31:0] rdata [3];
    logic [2:0]  ready;
    logic [2:0]  waiting;

    int total = 0;
    int bad   = 0;
    int nbits [3];
    int par   [3];

    always #5 clk = ~clk;

    uart_rx_multi #(.CLOCK_RATE(32000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(32)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en[0]), .o_rdata(rdata[0]),
        .o_ready(ready[0]), .o_waiting(waiting[0]), .UART_RX(line[0]));

    uart_rx_multi #(.CLOCK_RATE(32000000), .BAUD_RATE(1000000), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(32)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_enable(en[1]), .o_rdata(rdata[1]),
        .o_ready(ready[1]), .o_waiting(waiting[1]), .UART_RX(line[1]));

    uart_rx_multi #(.CLOCK_RATE(32000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .i_clock(clk), .i_reset(rst), .i_enable(en[2]), .o_rdata(rdata[2]),
        .o_ready(ready[2]), .o_waiting(waiting[2]), .UART_RX(line[2]));

    typedef struct {
        int          idx;
        logic [7:0]  data;
        bit          flip;
        bit          stop_low;
        int          gbit;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bit cell; optional 2-clock (one tick) inverted glitch around sample 8.
    task automatic drive_bit(input int idx, input logic v, input bit glitch);
        for (int c = 0; c < BIT_CLKS; c++) begin
            @(negedge clk);
            line[idx] = (glitch && (c == 17 || c == 18)) ? ~v : v;
        end
    endtask

    task automatic send_frame(input int idx, input logic [7:0] data, input bit flip,
                              input bit stop_low, input int gbit);
        logic p;
        drive_bit(idx, 1'b0, 1'b0);
        p = 1'b0;
        for (int i = 0; i < nbits[idx]; i++) begin
            drive_bit(idx, data[i], i == gbit);
            p ^= data[i];
        end
        if (par[idx] != 0) begin
            if (par[idx] == 2) p = ~p;
            drive_bit(idx, flip ? ~p : p, 1'b0);
        end
        drive_bit(idx, ~stop_low, 1'b0);
        if (stop_low) begin
            for (int i = 0; i < 3; i++) drive_bit(idx, 1'b0, 1'b0);
        end
        drive_bit(idx, 1'b1, 1'b0);
    endtask

    // Bus read; lat = clocks from i_enable to o_ready, -1 on timeout.
    task automatic bus_read(input int idx, output logic [31:0] d, output int lat);
        @(negedge clk);
        en[idx] = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (ready[idx]) break;
        end
        if (!ready[idx]) lat = -1;
        d = rdata[idx];
        en[idx] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          lat;
        logic [9:0]  expq [$];
        logic [9:0]  e;
        logic [7:0]  rd8;
        bit          fl;
        bit          sl;
        int          idx;

        nbits[0] = 8; nbits[1] = 7; nbits[2] = 8;
        par[0]   = 0; par[1]   = 2; par[2]   = 0;

        vt[0] = '{0, 8'hA5, 1'b0, 1'b0, -1, 32'h0000_00A5};
        vt[1] = '{1, 8'h35, 1'b0, 1'b0, -1, 32'h0000_0035};
        vt[2] = '{1, 8'h35, 1'b1, 1'b0, -1, 32'h0000_0135};
        vt[3] = '{0, 8'h3C, 1'b0, 1'b1, -1, 32'h0000_023C};
        vt[4] = '{0, 8'h11, 1'b0, 1'b0, -1, 32'h0000_0011};
        vt[5] = '{0, 8'h5A, 1'b0, 1'b0,  3, 32'h0000_005A};
        vt[6] = '{1, 8'h2A, 1'b0, 1'b0,  2, 32'h0000_002A};
        vt[7] = '{2, 8'hC3, 1'b0, 1'b0, -1, 32'h0000_00C3};

        rst  = 1'b1;
        en   = '0;
        line = '1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata",   rdata[0], 32'h0);
        check("reset_ready",   32'(ready[0]), 32'h0);
        check("reset_waiting", 32'(waiting[0]), 32'h0);
        repeat (16) @(negedge clk);

        // Directed vectors: one frame then one read each.
        for (int v = 0; v < 8; v++) begin
            send_frame(vt[v].idx, vt[v].data, vt[v].flip, vt[v].stop_low, vt[v].gbit);
            bus_read(vt[v].idx, d, lat);
            check($sformatf("vec%0d_rdata", v), d, vt[v].exp);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
        end

        // Idle-line glitch must not push; then a pending read is served by 0x7E.
        @(negedge clk); line[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); line[0] = 1'b1;
        repeat (64) @(negedge clk);
        en[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_waiting", 32'(waiting[0]), 32'h1);
        check("glitch_no_ready", 32'(ready[0]), 32'h0);
        send_frame(0, 8'h7E, 1'b0, 1'b0, -1);
        check("wait_ready", 32'(ready[0]), 32'h1);
        check("wait_waiting_low", 32'(waiting[0]), 32'h0);
        check("wait_rdata", rdata[0], 32'h0000_007E);
        en[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("release_ready", 32'(ready[0]), 32'h0);

        // Depth-4 FIFO: fifth frame overflows, first read reports overrun.
        for (int i = 1; i <= 5; i++) send_frame(2, 8'(i), 1'b0, 1'b0, -1);
        bus_read(2, d, lat); check("ovr_read1", d, 32'h0003_0401);
        bus_read(2, d, lat); check("ovr_read2", d, 32'h0002_0002);
        bus_read(2, d, lat); check("ovr_read3", d, 32'h0001_0003);
        bus_read(2, d, lat); check("ovr_read4", d, 32'h0000_0004);

        // Randomized frames against a queue model of the FIFO contents.
        for (int r = 0; r < 4; r++) begin
            idx = r % 2;
            for (int f = 0; f < 4; f++) begin
                rd8 = 8'($urandom_range(0, 255));
                if (nbits[idx] == 7) rd8[7] = 1'b0;
                fl  = (par[idx] != 0) && ($urandom_range(0, 3) == 0);
                sl  = ($urandom_range(0, 4) == 0);
                send_frame(idx, rd8, fl, sl, -1);
                expq.push_back({sl, fl, rd8});
            end
            while (expq.size() > 0) begin
                e = expq.pop_front();
                bus_read(idx, d, lat);
                check($sformatf("rand%0d_rdata", r), d, {16'(expq.size()), 6'b0, e});
                check($sformatf("rand%0d_latency", r), 32'(lat), 32'd2);
            end
        end

        // Reset in the middle of a frame: outputs cleared, nothing pushed.
        fork
            send_frame(0, 8'h00, 1'b0, 1'b0, -1);
            begin
                repeat (100) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("midreset_rdata",   rdata[0], 32'h0);
                check("midreset_ready",   32'(ready[0]), 32'h0);
                check("midreset_waiting", 32'(waiting[0]), 32'h0);
                rst = 1'b0;
            end
        join
        repeat (64) @(negedge clk);
        en[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_push", 32'({ready[0], waiting[0]}), 32'h1);
        en[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
